// File: rtl/z0_pkg.sv
// Shared definitions for the z0 multicycle core: opcodes, FSM states and
// instruction field positions.
package z0_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_MOV   = 4'h1;
  localparam logic [3:0] OP_LDI   = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_STORE = 4'h4;
  localparam logic [3:0] OP_ADD   = 4'h5;
  localparam logic [3:0] OP_SUB   = 4'h6;
  localparam logic [3:0] OP_JZ    = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 4;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

endpackage

// File: rtl/z0_if.sv
// Shared memory port of the z0 core: one request/acknowledge channel used for
// both instruction fetches and data accesses.
interface z0_mem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/z0_regfile.sv
// General-purpose register file: two asynchronous read ports, one
// synchronous write port, cleared by the asynchronous reset.
module z0_regfile #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(NREGS)-1:0] raddr_a,
  input  logic [$clog2(NREGS)-1:0] raddr_b,
  output logic [DATA_W-1:0]        rdata_a,
  output logic [DATA_W-1:0]        rdata_b
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/z0_core.sv
// z0 multicycle core: fetch/execute/memory sequencer over a shared memory
// port, with an NREGS-entry register file and Z/C status flags.
module z0_core
  import z0_pkg::*;
#(
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 16,
  parameter int          NREGS    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  z0_mem_if.master          mem,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              illegal
);

  localparam int RIDX_W = $clog2(NREGS);

  state_t            state, state_nx;
  logic [15:0]       ir;
  logic              flag_z, flag_c;
  logic [3:0]        op;
  logic [RIDX_W-1:0] rd_idx, rs_idx;
  logic [DATA_W-1:0] rd_val, rs_val;
  logic [DATA_W:0]   sum, diff;
  logic [ADDR_W-1:0] data_addr;

  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic              upd_flags, new_z, new_c;
  logic              take_jump, set_illegal;

  assign op     = ir[OP_MSB:OP_LSB];
  assign rd_idx = RIDX_W'(ir[RD_MSB:RD_LSB]);
  assign rs_idx = RIDX_W'(ir[RS_MSB:RS_LSB]);

  z0_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (rd_idx),
    .wdata   (rf_wdata),
    .raddr_a (rd_idx),
    .raddr_b (rs_idx),
    .rdata_a (rd_val),
    .rdata_b (rs_val)
  );

  // Extra top bit carries the ADD carry-out and the SUB borrow.
  assign sum  = {1'b0, rd_val} + {1'b0, rs_val};
  assign diff = {1'b0, rd_val} - {1'b0, rs_val};

  assign data_addr = (op == OP_STORE) ? ADDR_W'(rd_val) : ADDR_W'(rs_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    rf_we       = 1'b0;
    rf_wdata    = rs_val;
    upd_flags   = 1'b0;
    new_z       = 1'b0;
    new_c       = 1'b0;
    take_jump   = 1'b0;
    set_illegal = 1'b0;
    case (state)
      ST_FETCH: if (mem.ack) state_nx = ST_EXEC;
      ST_EXEC: begin
        state_nx = ST_FETCH;
        case (op)
          OP_NOP: ;
          OP_MOV: rf_we = 1'b1;
          OP_LDI: begin
            rf_we    = 1'b1;
            rf_wdata = DATA_W'(ir[IMM_MSB:IMM_LSB]);
          end
          OP_LOAD, OP_STORE: state_nx = ST_MEM;
          OP_ADD: begin
            rf_we     = 1'b1;
            rf_wdata  = sum[DATA_W-1:0];
            upd_flags = 1'b1;
            new_z     = (sum[DATA_W-1:0] == '0);
            new_c     = sum[DATA_W];
          end
          OP_SUB: begin
            rf_we     = 1'b1;
            rf_wdata  = diff[DATA_W-1:0];
            upd_flags = 1'b1;
            new_z     = (diff[DATA_W-1:0] == '0);
            new_c     = diff[DATA_W];
          end
          OP_JZ:   take_jump = flag_z;
          OP_HALT: state_nx = ST_HALT;
          default: begin
            set_illegal = 1'b1;
            state_nx    = ST_HALT;
          end
        endcase
      end
      ST_MEM: begin
        if (mem.ack) begin
          state_nx = ST_FETCH;
          if (op == OP_LOAD) begin
            rf_we    = 1'b1;
            rf_wdata = mem.rdata;
          end
        end
      end
      ST_HALT: state_nx = ST_HALT;
      default: state_nx = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= ADDR_W'(RESET_PC);
      ir      <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      if (state == ST_FETCH && mem.ack) begin
        ir <= mem.rdata[15:0];
        pc <= pc + ADDR_W'(1);
      end
      if (take_jump) pc <= ADDR_W'(ir[IMM_MSB:IMM_LSB]);
      if (upd_flags) begin
        flag_z <= new_z;
        flag_c <= new_c;
      end
      if (set_illegal) illegal <= 1'b1;
    end
  end

  // Request is gated by reset so an in-flight access is dropped immediately.
  assign mem.req   = rst_n && (state == ST_FETCH || state == ST_MEM);
  assign mem.we    = (state == ST_MEM) && (op == OP_STORE);
  assign mem.addr  = (state == ST_MEM) ? data_addr : pc;
  assign mem.wdata = (state == ST_MEM && op == OP_STORE) ? rs_val : '0;
  assign halted    = (state == ST_HALT);

endmodule
